// File: rtl/axi4lite_status_pkg.sv
// Shared constants, FSM state types and the byte-strobe merge helper for the
// AXI4-Lite status/control register slave.
package axi4lite_status_pkg;

  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

  // Merge new_v into old_v one byte lane at a time under strb.
  function automatic logic [AXI_DATA_W-1:0] apply_strb(
    input logic [AXI_DATA_W-1:0] old_v,
    input logic [AXI_DATA_W-1:0] new_v,
    input logic [AXI_STRB_W-1:0] strb
  );
    logic [AXI_DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < int'(AXI_STRB_W); b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4lite_status_slave_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4lite_status_slave_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4lite_status_regfile.sv
// Strobed control register array with per-register write pulses and the
// combinational read decode (control, status and out-of-range words).
module axi4lite_status_regfile
  import axi4lite_status_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  input  logic [DATA_WIDTH-1:0]          status_in,
  output logic                           wr_ok_c,
  output logic [DATA_WIDTH-1:0]          rd_data_c,
  output logic [1:0]                     rd_resp_c,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_regs,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                 wr_pulse_q, wr_pulse_d;
  logic [IDX_W-1:0]                    wr_idx, rd_idx;
  logic                                unused_addr_lsbs;

  assign wr_idx           = wr_addr[ADDR_WIDTH-1:2];
  assign rd_idx           = rd_addr[ADDR_WIDTH-1:2];
  assign unused_addr_lsbs = ^{wr_addr[1:0], rd_addr[1:0]};

  // Only control words are writable; status and holes answer SLVERR.
  assign wr_ok_c = (wr_idx < IDX_W'(NUM_REGS));

  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (wr_en) begin
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        if (wr_idx == IDX_W'(k)) begin
          regs_d[k]     = apply_strb(regs_q[k], wr_data, wr_strb);
          wr_pulse_d[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_SLVERR;
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      if (rd_idx == IDX_W'(k)) begin
        rd_data_c = regs_q[k];
        rd_resp_c = RESP_OKAY;
      end
    end
    if (rd_idx == IDX_W'(NUM_REGS)) begin
      rd_data_c = status_in;
      rd_resp_c = RESP_OKAY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q     <= '0;
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign ctrl_regs = regs_q;
  assign wr_pulse  = wr_pulse_q;

endmodule

// File: rtl/axi4lite_status_slave.sv
// AXI4-Lite register slave: independent write and read channel FSMs in front
// of the control register file, one outstanding transaction per channel.
module axi4lite_status_slave
  import axi4lite_status_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  axi4lite_status_slave_if.slave         s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_regs,
  output logic [NUM_REGS-1:0]            wr_pulse,
  input  logic [DATA_WIDTH-1:0]          status_in
);

  wr_state_t               wr_state_q, wr_state_d;
  rd_state_t               rd_state_q, rd_state_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    commit_c;
  logic                    wr_ok_c;
  logic [DATA_WIDTH-1:0]   rd_data_c;
  logic [1:0]              rd_resp_c;
  logic                    unused_prot;

  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

  axi4lite_status_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_regfile (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (commit_c),
    .wr_addr   (awaddr_q),
    .wr_data   (wdata_q),
    .wr_strb   (wstrb_q),
    .rd_addr   (s_axi.araddr),
    .status_in (status_in),
    .wr_ok_c   (wr_ok_c),
    .rd_data_c (rd_data_c),
    .rd_resp_c (rd_resp_c),
    .ctrl_regs (ctrl_regs),
    .wr_pulse  (wr_pulse)
  );

  // Write channel: capture AW and W independently, commit once both are held.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    commit_c   = 1'b0;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (awready_q && s_axi.awvalid) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi.awaddr;
        end
        if (wready_q && s_axi.wvalid) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.wdata;
          wstrb_d  = s_axi.wstrb;
        end
        if (aw_held_q && w_held_q) begin
          commit_c   = 1'b1;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = wr_ok_c ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = WR_RESP;
        end else begin
          awready_d = ~aw_held_d;
          wready_d  = ~w_held_d;
        end
      end
      WR_RESP: begin
        if (s_axi.bready) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Read channel: the register mux is sampled on the AR handshake edge.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (arready_q && s_axi.arvalid) begin
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = rd_data_c;
          rresp_d    = rd_resp_c;
          rd_state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (s_axi.rready) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

endmodule

// File: tb/tb_axi4lite_status_slave.sv
// Directed self-checking bench for axi4lite_status_slave.
module tb_axi4lite_status_slave;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic         clock;
  logic         reset;
  logic [127:0] ctrl_regs;
  logic [3:0]   wr_pulse;
  logic [31:0]  status_in;

  int total;
  int passed;

  axi4lite_status_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifc ();

  axi4lite_status_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .NUM_REGS   (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .s_axi     (ifc.slave),
    .ctrl_regs (ctrl_regs),
    .wr_pulse  (wr_pulse),
    .status_in (status_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, awf, wf;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    ifc.awaddr = addr; ifc.awvalid = 1'b1;
    ifc.wdata = data; ifc.wstrb = strb; ifc.wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      awf = ifc.awvalid && ifc.awready;
      wf  = ifc.wvalid && ifc.wready;
      step(); n++;
      if (awf) begin ifc.awvalid = 1'b0; aw_done = 1; end
      if (wf)  begin ifc.wvalid  = 1'b0; w_done  = 1; end
    end
    ifc.awvalid = 1'b0; ifc.wvalid = 1'b0;
    chk("wr_accept", {aw_done, w_done}, 2'b11);
    n = 0;
    while (!ifc.bvalid && n < 20) begin step(); n++; end
    chk("wr_bvalid", ifc.bvalid, 1'b1);
    resp = ifc.bresp;
    ifc.bready = 1'b1;
    step();
    ifc.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit ar_done, arf;
    int n;
    ar_done = 0; n = 0;
    ifc.araddr = addr; ifc.arvalid = 1'b1;
    while (!ar_done && n < 20) begin
      arf = ifc.arvalid && ifc.arready;
      step(); n++;
      if (arf) begin ifc.arvalid = 1'b0; ar_done = 1; end
    end
    ifc.arvalid = 1'b0;
    n = 0;
    while (!ifc.rvalid && n < 20) begin step(); n++; end
    chk("rd_rvalid", {ar_done, ifc.rvalid}, 2'b11);
    data = ifc.rdata;
    resp = ifc.rresp;
    ifc.rready = 1'b1;
    step();
    ifc.rready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs, ws;
    bit          b_seen;
    total = 0; passed = 0;
    reset = 1'b1;
    status_in = 32'hCAFE0001;
    ifc.awaddr = '0; ifc.awprot = 3'b000; ifc.awvalid = 1'b0;
    ifc.wdata = '0; ifc.wstrb = '0; ifc.wvalid = 1'b0; ifc.bready = 1'b0;
    ifc.araddr = '0; ifc.arprot = 3'b000; ifc.arvalid = 1'b0; ifc.rready = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst_rdy_vld", {ifc.awready, ifc.wready, ifc.arready, ifc.bvalid, ifc.rvalid}, 5'b0);
    chk("rst_resp", {ifc.bresp, ifc.rresp}, 4'b0);
    chk("rst_rdata", ifc.rdata, 32'h0);
    chk("rst_ctrl", ctrl_regs, 128'h0);
    chk("rst_pulse", wr_pulse, 4'b0);
    reset = 1'b0;
    step();
    chk("rdy_after_rst", {ifc.awready, ifc.wready, ifc.arready}, 3'b111);

    // Sequential writes then readback
    for (int k = 0; k < 4; k++) begin
      axi_write(5'(k * 4), 32'(k + 1), 4'hF, ws);
      chk("seq_bresp", ws, OKAY);
    end
    chk("seq_ctrl", ctrl_regs, 128'h00000004_00000003_00000002_00000001);
    for (int k = 0; k < 4; k++) begin
      axi_read(5'(k * 4), rd, rs);
      chk("seq_rdata", rd, 32'(k + 1));
      chk("seq_rresp", rs, OKAY);
    end

    // W three cycles before AW
    ifc.awaddr = 5'h04; ifc.wdata = 32'hDEADBEEF; ifc.wstrb = 4'hF; ifc.wvalid = 1'b1;
    step();
    ifc.wvalid = 1'b0;
    chk("wfirst_wready_drop", ifc.wready, 1'b0);
    step(); step();
    chk("wfirst_wait", {ifc.wready, ifc.bvalid, ifc.awready}, 3'b001);
    ifc.awvalid = 1'b1;
    step();
    ifc.awvalid = 1'b0;
    chk("wfirst_hs_edge", {ifc.bvalid, wr_pulse, ifc.awready}, 6'b0);
    step();
    chk("wfirst_bvalid", ifc.bvalid, 1'b1);
    chk("wfirst_pulse", wr_pulse, 4'b0010);
    chk("wfirst_ctrl", ctrl_regs[63:32], 32'hDEADBEEF);
    step();
    chk("wfirst_pulse_end", {wr_pulse, ifc.bvalid}, 5'b00001);
    ifc.bready = 1'b1;
    step();
    ifc.bready = 1'b0;
    chk("wfirst_bdone", {ifc.bvalid, ifc.awready, ifc.wready}, 3'b011);

    // Byte strobes
    axi_write(5'h00, 32'h11223344, 4'hF, ws);
    axi_write(5'h00, 32'hAABBCCDD, 4'b0101, ws);
    chk("strb_bresp", ws, OKAY);
    axi_read(5'h00, rd, rs);
    chk("strb_rdata", rd, 32'h11BB33DD);

    // Zero strobe leaves data unchanged
    axi_write(5'h0C, 32'hFFFFFFFF, 4'h0, ws);
    chk("zstrb_bresp", ws, OKAY);
    chk("zstrb_ctrl", ctrl_regs[127:96], 32'h4);

    // Status word and out-of-range decode
    axi_read(5'h10, rd, rs);
    chk("stat_rdata", rd, 32'hCAFE0001);
    chk("stat_rresp", rs, OKAY);
    axi_write(5'h10, 32'h12345678, 4'hF, ws);
    chk("stat_wr_bresp", ws, SLVERR);
    chk("stat_wr_ctrl", ctrl_regs, 128'h00000004_00000003_DEADBEEF_11BB33DD);
    axi_read(5'h14, rd, rs);
    chk("oor_rdata", rd, 32'h0);
    chk("oor_rresp", rs, SLVERR);
    axi_write(5'h1C, 32'h1, 4'hF, ws);
    chk("oor_wr_bresp", ws, SLVERR);

    // AR handshake on the commit edge returns the old value
    ifc.awaddr = 5'h08; ifc.wdata = 32'h55; ifc.wstrb = 4'hF;
    ifc.awvalid = 1'b1; ifc.wvalid = 1'b1;
    step();
    ifc.awvalid = 1'b0; ifc.wvalid = 1'b0;
    ifc.araddr = 5'h08; ifc.arvalid = 1'b1;
    step();
    ifc.arvalid = 1'b0;
    chk("same_edge_vld", {ifc.rvalid, ifc.bvalid}, 2'b11);
    chk("same_edge_old", ifc.rdata, 32'h3);
    chk("same_edge_ctrl", ctrl_regs[95:64], 32'h55);
    ifc.bready = 1'b1; ifc.rready = 1'b1;
    step();
    ifc.bready = 1'b0; ifc.rready = 1'b0;
    axi_read(5'h08, rd, rs);
    chk("same_edge_new", rd, 32'h55);

    // Stalled B and R responses
    ifc.awaddr = 5'h04; ifc.wdata = 32'h12345678; ifc.wstrb = 4'hF; ifc.araddr = 5'h04;
    ifc.awvalid = 1'b1; ifc.wvalid = 1'b1; ifc.arvalid = 1'b1;
    step();
    ifc.awvalid = 1'b0; ifc.wvalid = 1'b0; ifc.arvalid = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("stall_vld", {ifc.bvalid, ifc.rvalid, ifc.bresp, ifc.rresp}, 6'b110000);
      chk("stall_rdata", ifc.rdata, 32'hDEADBEEF);
      chk("stall_rdy", {ifc.awready, ifc.wready, ifc.arready}, 3'b000);
      step();
    end
    ifc.bready = 1'b1; ifc.rready = 1'b1;
    step();
    ifc.bready = 1'b0; ifc.rready = 1'b0;
    chk("stall_release", {ifc.bvalid, ifc.rvalid, ifc.awready, ifc.wready, ifc.arready}, 5'b00111);
    chk("stall_ctrl", ctrl_regs[63:32], 32'h12345678);

    // Reset between AW and W aborts the write
    ifc.awaddr = 5'h08; ifc.awvalid = 1'b1;
    step();
    ifc.awvalid = 1'b0;
    reset = 1'b1;
    step();
    chk("abort_rdy_vld", {ifc.awready, ifc.wready, ifc.arready, ifc.bvalid, ifc.rvalid}, 5'b0);
    chk("abort_ctrl", ctrl_regs, 128'h0);
    chk("abort_misc", {wr_pulse, ifc.bresp, ifc.rresp, ifc.rdata}, 40'h0);
    reset = 1'b0;
    b_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      b_seen = b_seen | ifc.bvalid;
    end
    chk("abort_no_b", b_seen, 1'b0);
    axi_write(5'h08, 32'h77, 4'hF, ws);
    chk("abort_next_bresp", ws, OKAY);
    chk("abort_next_ctrl", ctrl_regs, 128'h00000000_00000077_00000000_00000000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
